vec_result_collector: RTL and testbench



---
 rtl/vec_result_collector.sv | 167 ++++++++++++++++
 tb/tb_vec_result_collector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_result_collector.sv
// vec_result_collector: gathers per-lane ALU result chunks into one vector
// register image, then presents it as a single writeback request.
// A collection runs IDLE -> COLLECT -> WB -> IDLE. Each valid lane chunk is
// merged at its bit offset. Higher-numbered lanes win on overlap. A chunk that
// would spill past VLEN, or any chunk under an illegal vsew, is dropped and
// sets the sticky err flag.
module vec_result_collector #(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned NB_LANES   = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      vsew,
    input  logic [4:0]      vd_addr,
    input  logic [63:0]     vd0,
    input  logic [63:0]     vd1,
    input  logic [63:0]     vd2,
    input  logic [63:0]     vd3,
    input  logic [9:0]      regi0,
    input  logic [9:0]      regi1,
    input  logic [9:0]      regi2,
    input  logic [9:0]      regi3,
    input  logic            res0,
    input  logic            res1,
    input  logic            res2,
    input  logic            res3,
    input  logic            done_in,
    input  logic            wb_ready,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [VLEN-1:0] wb_data,
    output logic            busy,
    output logic            err
);

    localparam int unsigned NLANES   = 1 << NB_LANES;
    localparam int unsigned MAXW_RAW = 1 << LANE_WIDTH;
    localparam int unsigned MAXW     = (MAXW_RAW > 64) ? 64 : MAXW_RAW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WB
    } state_t;

    state_t          state_q;
    logic [2:0]      vsew_q;
    logic [4:0]      vd_addr_q;
    logic [VLEN-1:0] acc_q;
    logic [VLEN-1:0] acc_d;
    logic            err_q;
    logic            err_hit;
    logic            wb_valid_q;
    logic            busy_q;

    logic [63:0]     vd_a   [4];
    logic [9:0]      regi_a [4];
    logic [3:0]      res_a;

    int unsigned     chunk_w;
    logic [63:0]     chunk_mask;
    logic [VLEN-1:0] field;
    logic [VLEN-1:0] data;

    assign vd_a[0]   = vd0;
    assign vd_a[1]   = vd1;
    assign vd_a[2]   = vd2;
    assign vd_a[3]   = vd3;
    assign regi_a[0] = regi0;
    assign regi_a[1] = regi1;
    assign regi_a[2] = regi2;
    assign regi_a[3] = regi3;
    assign res_a     = {res3, res2, res1, res0};

    // Chunk width from the latched element width, capped at the lane width.
    always_comb begin
        chunk_w    = 0;
        chunk_mask = '0;
        if (vsew_q <= 3'd3) begin
            chunk_w = 8 << vsew_q;
            if (chunk_w > MAXW) begin
                chunk_w = MAXW;
            end
        end
        for (int unsigned b = 0; b < 64; b++) begin
            chunk_mask[b] = (b < chunk_w);
        end
    end

    // Merge this cycle's lane chunks in ascending lane order so the highest lane wins.
    always_comb begin
        acc_d   = acc_q;
        err_hit = 1'b0;
        field   = '0;
        data    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < NLANES && res_a[i]) begin
                if (vsew_q > 3'd3) begin
                    err_hit = 1'b1;
                end else if ((32'(regi_a[i]) + chunk_w) > VLEN) begin
                    err_hit = 1'b1;
                end else begin
                    field = VLEN'(chunk_mask) << regi_a[i];
                    data  = VLEN'(vd_a[i] & chunk_mask) << regi_a[i];
                    acc_d = (acc_d & ~field) | data;
                end
            end
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            vsew_q     <= '0;
            vd_addr_q  <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_COLLECT;
                        acc_q     <= '0;
                        err_q     <= 1'b0;
                        vsew_q    <= vsew;
                        vd_addr_q <= vd_addr;
                        busy_q    <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    acc_q <= acc_d;
                    if (err_hit) begin
                        err_q <= 1'b1;
                    end
                    if (done_in) begin
                        state_q    <= S_WB;
                        wb_valid_q <= 1'b1;
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    wb_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = vd_addr_q;
    assign wb_data  = acc_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vec_result_collector.sv
// Directed bench for vec_result_collector with hand-computed expectations.
module tb_vec_result_collector;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [2:0]   vsew;
    logic [4:0]   vd_addr;
    logic [63:0]  vd0, vd1, vd2, vd3;
    logic [9:0]   regi0, regi1, regi2, regi3;
    logic         res0, res1, res2, res3;
    logic         done_in;
    logic         wb_ready;
    logic         wb_valid;
    logic [4:0]   wb_addr;
    logic [127:0] wb_data;
    logic         busy;
    logic         err;

    int nvec;
    int nmis;

    vec_result_collector #(
        .VLEN      (128),
        .LANE_WIDTH(4),
        .NB_LANES  (2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .vsew     (vsew),
        .vd_addr  (vd_addr),
        .vd0      (vd0),
        .vd1      (vd1),
        .vd2      (vd2),
        .vd3      (vd3),
        .regi0    (regi0),
        .regi1    (regi1),
        .regi2    (regi2),
        .regi3    (regi3),
        .res0     (res0),
        .res1     (res1),
        .res2     (res2),
        .res3     (res3),
        .done_in  (done_in),
        .wb_ready (wb_ready),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        res0 = 0; res1 = 0; res2 = 0; res3 = 0;
        vd0 = '0; vd1 = '0; vd2 = '0; vd3 = '0;
        regi0 = '0; regi1 = '0; regi2 = '0; regi3 = '0;
        done_in = 0;
    endtask

    task automatic do_start(input logic [2:0] sew, input logic [4:0] addr);
        start = 1; vsew = sew; vd_addr = addr;
        step();
        start = 0; vsew = '0; vd_addr = '0;
    endtask

    initial begin
        nvec = 0; nmis = 0;
        resetn = 0; start = 0; vsew = '0; vd_addr = '0; wb_ready = 1;
        clear_lanes();
        step(); step();
        check("rst_valid", 128'(wb_valid), 128'h0);
        check("rst_busy",  128'(busy),     128'h0);
        check("rst_err",   128'(err),      128'h0);
        check("rst_addr",  128'(wb_addr),  128'h0);
        check("rst_data",  wb_data,        128'h0);
        resetn = 1;
        step();

        // Byte gather over 4 beats; a start mid-collect must be ignored.
        do_start(3'd0, 5'd5);
        check("t1_busy", 128'(busy), 128'h1);
        for (int k = 0; k < 4; k++) begin
            res0 = 1; res1 = 1; res2 = 1; res3 = 1;
            regi0 = 10'(8 * (4 * k + 0)); vd0 = 64'(8'h10 + 4 * k + 0);
            regi1 = 10'(8 * (4 * k + 1)); vd1 = 64'(8'h10 + 4 * k + 1);
            regi2 = 10'(8 * (4 * k + 2)); vd2 = 64'(8'h10 + 4 * k + 2);
            regi3 = 10'(8 * (4 * k + 3)); vd3 = 64'(8'h10 + 4 * k + 3);
            if (k == 1) begin
                start = 1; vsew = 3'd3; vd_addr = 5'd9;
            end
            done_in = (k == 3);
            if (k == 3) check("t1_pre_valid", 128'(wb_valid), 128'h0);
            step();
            start = 0; vsew = '0; vd_addr = '0;
            clear_lanes();
        end
        check("t1_valid", 128'(wb_valid), 128'h1);
        check("t1_data",  wb_data, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        check("t1_addr",  128'(wb_addr), 128'd5);
        check("t1_err",   128'(err), 128'h0);
        step();
        check("t1_idle_valid", 128'(wb_valid), 128'h0);
        check("t1_idle_busy",  128'(busy), 128'h0);

        // 16-bit chunks with junk above the chunk; wb_ready already high.
        do_start(3'd2, 5'd7);
        res0 = 1; regi0 = 10'd0; vd0 = 64'hFFFF_FFFF_FFFF_BEEF;
        step();
        clear_lanes();
        res0 = 1; regi0 = 10'd16; vd0 = 64'h1234_5678_9ABC_DEAD; done_in = 1;
        step();
        clear_lanes();
        check("t2_valid", 128'(wb_valid), 128'h1);
        check("t2_data",  wb_data, 128'hDEADBEEF);
        check("t2_addr",  128'(wb_addr), 128'd7);
        check("t2_err",   128'(err), 128'h0);
        step();
        check("t2_one_cycle", 128'(wb_valid), 128'h0);

        // Overlap priority, overflow drop, then a 5-cycle writeback stall.
        wb_ready = 0;
        do_start(3'd0, 5'd3);
        res1 = 1; regi1 = 10'd32; vd1 = 64'h3311;
        res2 = 1; regi2 = 10'd32; vd2 = 64'h4422;
        step();
        clear_lanes();
        res0 = 1; regi0 = 10'd124; vd0 = 64'hAB;
        res3 = 1; regi3 = 10'd120; vd3 = 64'h77;
        done_in = 1;
        step();
        clear_lanes();
        check("t3_err", 128'(err), 128'h1);
        for (int c = 0; c < 5; c++) begin
            check("t3_stall_valid", 128'(wb_valid), 128'h1);
            check("t3_stall_data",  wb_data, 128'h77000000_00000000_00000022_00000000);
            check("t3_stall_addr",  128'(wb_addr), 128'd3);
            step();
        end
        wb_ready = 1;
        step();
        check("t3_idle_valid", 128'(wb_valid), 128'h0);
        check("t3_idle_busy",  128'(busy), 128'h0);
        check("t3_err_sticky", 128'(err), 128'h1);
        do_start(3'd0, 5'd4);
        check("t3_err_clear", 128'(err), 128'h0);
        check("t3_acc_clear", wb_data, 128'h0);

        // Reset mid-collect after two beats, then a clean operation.
        res0 = 1; regi0 = 10'd0; vd0 = 64'hAA;
        step();
        clear_lanes();
        res1 = 1; regi1 = 10'd8; vd1 = 64'hAA;
        step();
        clear_lanes();
        resetn = 0;
        step();
        resetn = 1;
        check("t4_rst_busy",  128'(busy), 128'h0);
        check("t4_rst_valid", 128'(wb_valid), 128'h0);
        check("t4_rst_data",  wb_data, 128'h0);
        check("t4_rst_addr",  128'(wb_addr), 128'h0);
        do_start(3'd0, 5'd12);
        res0 = 1; regi0 = 10'd0; vd0 = 64'h55; done_in = 1;
        step();
        clear_lanes();
        check("t4_valid", 128'(wb_valid), 128'h1);
        check("t4_data",  wb_data, 128'h55);
        check("t4_addr",  128'(wb_addr), 128'd12);
        step();

        // Illegal vsew drops every chunk and flags err; lane traffic in IDLE is ignored.
        do_start(3'd5, 5'd1);
        res0 = 1; regi0 = 10'd0; vd0 = 64'h99; done_in = 1;
        step();
        clear_lanes();
        check("t5_valid", 128'(wb_valid), 128'h1);
        check("t5_data",  wb_data, 128'h0);
        check("t5_err",   128'(err), 128'h1);
        step();
        res0 = 1; regi0 = 10'd0; vd0 = 64'h66; done_in = 1;
        step();
        clear_lanes();
        check("t5_idle_data",  wb_data, 128'h0);
        check("t5_idle_busy",  128'(busy), 128'h0);
        check("t5_idle_valid", 128'(wb_valid), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
